// File: rtl/usb_rx_timer_ctrl.sv
// usb_rx_timer_ctrl: bit-period sampling and byte framing control for the USB receiver.
// Optional feature: define USB_RX_RESYNC_EN to realign the sample counter on every d_edge in RUN.
module usb_rx_timer_ctrl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rcving,
    input  logic       d_edge,
    input  logic       stall,
    output logic       shift_enable,
    output logic       byte_received,
    output logic       byte_abort,
    output logic [2:0] bit_index,
    output logic       active
);
    localparam logic [3:0] CPB = 4'(CLKS_PER_BIT);
    localparam logic [3:0] SPH = 4'(SAMPLE_PHASE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [3:0] sample_cnt;
    logic [3:0] next_cnt;
    logic       last_bit;

    // Sample strobe is a pure decode so a stall removes it in the same cycle.
    always_comb begin
        shift_enable = (state == RUN) && (sample_cnt == SPH) && !stall;
        last_bit     = shift_enable && (bit_index == 3'd7);
    end

    // Counter runs 1..CLKS_PER_BIT; with resync a line transition restarts the bit period.
    always_comb begin
`ifdef USB_RX_RESYNC_EN
        next_cnt = (d_edge || sample_cnt == CPB) ? 4'd1 : sample_cnt + 4'd1;
`else
        next_cnt = (sample_cnt == CPB) ? 4'd1 : sample_cnt + 4'd1;
`endif
    end

    // IDLE/RUN control with registered byte-level pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            sample_cnt    <= 4'd0;
            bit_index     <= 3'd0;
            byte_received <= 1'b0;
            byte_abort    <= 1'b0;
            active        <= 1'b0;
        end else begin
            byte_received <= last_bit;
            byte_abort    <= 1'b0;
            if (state == IDLE) begin
                if (rcving && d_edge) begin
                    state      <= RUN;
                    active     <= 1'b1;
                    sample_cnt <= 4'd1;
                    bit_index  <= 3'd0;
                end
            end else if (!rcving) begin
                state      <= IDLE;
                active     <= 1'b0;
                sample_cnt <= 4'd0;
                bit_index  <= 3'd0;
                byte_abort <= (bit_index != 3'd0) && !last_bit;
            end else begin
                sample_cnt <= next_cnt;
                bit_index  <= bit_index + {2'b00, shift_enable};
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_timer_ctrl.sv
// tb_usb_rx_timer_ctrl: directed scenarios checked against a timing model plus literal cycle expectations.
module tb_usb_rx_timer_ctrl;
    localparam int CPB = 8;
    localparam int SP  = 3;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       rcving = 1'b0;
    logic       d_edge = 1'b0;
    logic       stall = 1'b0;
    logic       shift_enable;
    logic       byte_received;
    logic       byte_abort;
    logic       active;
    logic [2:0] bit_index;

    int total = 0;
    int passed = 0;
    int rel = 0;
    int sh_q[$];
    int br_q[$];
    int ab_q[$];
    int bi_log[128];
    int act_log[128];

    bit m_run = 1'b0;
    bit m_sh = 1'b0;
    int m_ref = 0;
    int m_bits = 0;
    int m_br = 0;
    int m_ab = 0;
    int cyc_n = 0;

    usb_rx_timer_ctrl #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .rcving(rcving),
        .d_edge(d_edge),
        .stall(stall),
        .shift_enable(shift_enable),
        .byte_received(byte_received),
        .byte_abort(byte_abort),
        .bit_index(bit_index),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a bit is sampled SP clocks after the reference edge and every CPB clocks after that.
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!n_rst) begin
                m_run = 1'b0;
                m_bits = 0;
                m_br = 0;
                m_ab = 0;
            end else begin
                m_sh = m_run && !stall && ((cyc_n - m_ref - SP) % CPB == 0);
                check("shift_enable", int'(shift_enable), int'(m_sh));
                check("byte_received", int'(byte_received), m_br);
                check("byte_abort", int'(byte_abort), m_ab);
                check("active", int'(active), int'(m_run));
                check("bit_index", int'(bit_index), m_bits);
                m_br = int'(m_sh && m_bits == 7);
                m_ab = int'(m_run && !rcving && m_bits != 0 && !(m_sh && m_bits == 7));
                if (!m_run) begin
                    if (rcving && d_edge) begin
                        m_run = 1'b1;
                        m_ref = cyc_n;
                        m_bits = 0;
                    end
                end else if (!rcving) begin
                    m_run = 1'b0;
                    m_bits = 0;
                end else begin
`ifdef USB_RX_RESYNC_EN
                    if (d_edge) m_ref = cyc_n;
`endif
                    if (m_sh) m_bits = (m_bits + 1) % 8;
                end
            end
        end
    end

    task automatic tick(input logic r, input logic d, input logic s);
        rcving = r;
        d_edge = d;
        stall = s;
        @(negedge clk);
        if (shift_enable) sh_q.push_back(rel);
        if (byte_received) br_q.push_back(rel);
        if (byte_abort) ab_q.push_back(rel);
        if (rel < 128) begin
            bi_log[rel] = int'(bit_index);
            act_log[rel] = int'(active);
        end
        rel++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rel = 0;
        sh_q.delete();
        br_q.delete();
        ab_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, i[0], 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_shift_enable"}, int'(shift_enable), 0);
        check({tag, "_byte_received"}, int'(byte_received), 0);
        check({tag, "_byte_abort"}, int'(byte_abort), 0);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_bit_index"}, int'(bit_index), 0);
    endtask

    initial begin
        #1 n_rst = 1'b0;
        #1 check_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1 n_rst = 1'b1;
        idle(6);

        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 63; i++) tick(1'b1, 1'b0, 1'b0);
        idle(4);
        check("clean_shifts", sh_q.size(), 8);
        check("clean_first_shift", sh_q[0], 3);
        check("clean_last_shift", sh_q[7], 59);
        check("clean_br_count", br_q.size(), 1);
        check("clean_br_cycle", br_q[0], 60);
        check("clean_aborts", ab_q.size(), 0);

        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 71; i++) tick(1'b1, 1'b0, i == 27);
        idle(4);
        check("stuff_shifts", sh_q.size(), 8);
        check("stuff_shift4", sh_q[3], 35);
        check("stuff_bi_hold", bi_log[28], 3);
        check("stuff_last_shift", sh_q[7], 67);
        check("stuff_br_cycle", br_q[0], 68);
        check("stuff_aborts", ab_q.size(), 0);

        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 30; i++) tick(1'b1, 1'b0, 1'b0);
        idle(6);
        check("abort_bi", bi_log[30], 4);
        check("abort_count", ab_q.size(), 1);
        check("abort_cycle", ab_q[0], 31);
        check("abort_active", act_log[31], 0);
        check("abort_br_count", br_q.size(), 0);

        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 21; i++) tick(1'b1, i == 14, 1'b0);
        idle(4);
`ifdef USB_RX_RESYNC_EN
        check("resync_shift3", sh_q[2], 17);
`else
        check("resync_shift3", sh_q[2], 19);
`endif

        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 59; i++) tick(1'b1, 1'b0, 1'b0);
        idle(4);
        check("late_drop_br_count", br_q.size(), 1);
        check("late_drop_br_cycle", br_q[0], 60);
        check("late_drop_aborts", ab_q.size(), 0);

        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 40; i++) tick(1'b1, 1'b0, 1'b0);
        check("rst_pre_bi", int'(bit_index), 5);
        check("rst_pre_active", int'(active), 1);
        n_rst = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1 n_rst = 1'b1;
        clr();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
        check("post_rst_shifts", sh_q.size(), 0);
        check("post_rst_aborts", ab_q.size(), 0);
        check("post_rst_active", act_log[19], 0);
        clr();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
        idle(3);
        check("post_rst_first_shift", sh_q[0], 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
